// File: rtl/mx_4.sv
// Four-to-one bitwise multiplexer with a zero-latency combinational output
// and an optional enabled output register carrying the select alongside it.
module mx_4 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_r,
    output logic [1:0]       s_r
);

    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] y_d, y_q;
    logic [1:0]       s_d, s_q;

    // An unknown select yields all-X in simulation; synthesis sees a don't-care.
    always_comb begin
        sel_y = 'x;
        case (s)
            2'b00:   sel_y = d0;
            2'b01:   sel_y = d1;
            2'b10:   sel_y = d2;
            2'b11:   sel_y = d3;
            default: sel_y = 'x;
        endcase
    end

    always_comb begin
        y_d = y_q;
        s_d = s_q;
        if (en) begin
            y_d = sel_y;
            s_d = s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q <= '0;
            s_q <= 2'b00;
        end else begin
            y_q <= y_d;
            s_q <= s_d;
        end
    end

    assign y   = sel_y;
    assign y_r = y_q;
    assign s_r = s_q;

endmodule

// File: tb/tb_mx_4.sv
// Scoreboard bench for mx_4: stimulus queues expected outputs from an
// array-indexed reference model, a monitor process pops and compares them.
module tb_mx_4;

    localparam int W = 8;

    logic         clk     = 1'b0;
    logic         clk_run = 1'b0;
    logic         reset_n = 1'b0;
    logic         en      = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [1:0]   s  = 2'b00;
    logic [W-1:0] y, y_r;
    logic [1:0]   s_r;

    mx_4 #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .s       (s),
        .y       (y),
        .y_r     (y_r),
        .s_r     (s_r)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] y;
        logic [W-1:0] yr;
        logic [1:0]   sr;
    } exp_t;

    exp_t         sb[$];
    event         chk_ev;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_yr = '0;
    logic [1:0]   m_sr = 2'b00;

    function automatic logic [W-1:0] ref_sel(input logic [1:0] sel,
                                             input logic [W-1:0] a, b, c, e);
        logic [W-1:0] v [4];
        v = '{a, b, c, e};
        return v[sel];
    endfunction

    task automatic expect_now(input string nm);
        exp_t e;
        e.name = nm;
        e.y    = ref_sel(s, d0, d1, d2, d3);
        e.yr   = m_yr;
        e.sr   = m_sr;
        sb.push_back(e);
        -> chk_ev;
        #2;
    endtask

    // Model of one rising edge; inputs are only driven away from posedge.
    task automatic tick();
        @(posedge clk);
        if (reset_n && en) begin
            m_yr = ref_sel(s, d0, d1, d2, d3);
            m_sr = s;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] sel, input logic [W-1:0] a, b, c, e);
        s = sel; d0 = a; d1 = b; d2 = c; d3 = e;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (y !== e.y) begin
                    n_bad++;
                    $display("FAIL %s.y: got %h expected %h", e.name, y, e.y);
                end
                n_cmp++;
                if (y_r !== e.yr) begin
                    n_bad++;
                    $display("FAIL %s.y_r: got %h expected %h", e.name, y_r, e.yr);
                end
                n_cmp++;
                if (s_r !== e.sr) begin
                    n_bad++;
                    $display("FAIL %s.s_r: got %b expected %b", e.name, s_r, e.sr);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0]   sel;
        logic [W-1:0] one;
        // Reset held, clock stopped: registers cleared, y still follows inputs.
        #3;
        expect_now("reset");
        drive(2'b10, '0, '0, 8'h01, '0);
        expect_now("comb_in_reset");
        if (y !== 8'h01 || y_r !== '0 || s_r !== 2'b00) begin
            n_bad++;
            $display("FAIL comb_in_reset_const: got y=%h y_r=%h s_r=%b expected 01/00/00", y, y_r, s_r);
        end
        n_cmp++;

        clk_run = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        for (int unsigned i = 0; i < 4; i++) begin
            sel = 2'(i);
            one = 8'h01;
            drive(sel, (i == 0) ? one : '0, (i == 1) ? one : '0,
                       (i == 2) ? one : '0, (i == 3) ? one : '0);
            expect_now($sformatf("sweep%0d", i));
            drive(sel, (i == 0) ? '0 : '1, (i == 1) ? '0 : '1,
                       (i == 2) ? '0 : '1, (i == 3) ? '0 : '1);
            expect_now($sformatf("exclude%0d", i));
        end

        en = 1'b1;
        drive(2'b01, '0, 8'hA5, '0, '0);
        expect_now("cap_comb");
        tick();
        expect_now("cap_reg");
        en = 1'b0;
        drive(2'b11, '0, 8'hA5, '0, 8'h3C);
        expect_now("hold_comb");
        tick();
        expect_now("hold_reg");

        // Asynchronous reset between edges, then release with en=1.
        en = 1'b1;
        drive(2'b01, '0, 8'hA5, '0, '0);
        tick();
        #1;
        reset_n = 1'b0;
        m_yr = '0;
        m_sr = 2'b00;
        expect_now("async_reset");
        @(negedge clk);
        expect_now("reset_held_edge");
        reset_n = 1'b1;
        drive(2'b10, 8'h11, 8'h22, 8'h5A, 8'h44);
        tick();
        expect_now("post_release");

        // Reset asserted coincident with a rising edge must win.
        @(posedge clk);
        reset_n = 1'b0;
        m_yr = '0;
        m_sr = 2'b00;
        #1;
        expect_now("reset_at_edge");
        @(negedge clk);
        reset_n = 1'b1;

        for (int unsigned k = 0; k < 1000; k++) begin
            en = 1'($urandom_range(0, 3) != 0);
            drive(2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            expect_now("rand_comb");
            tick();
            expect_now("rand_reg");
            if ($urandom_range(0, 49) == 0) begin
                #1;
                reset_n = 1'b0;
                m_yr = '0;
                m_sr = 2'b00;
                expect_now("rand_reset");
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        #5;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mx_4.md
# mx_4

Four-to-one multiplexer, the per-bit selection cell of the 8-bit shifter datapath (`Shifter8`). It selects one of four data inputs by a 2-bit select and drives the result combinationally on `y` with zero clock latency. A registered copy of the result, `y_r`, is also provided for pipelined shifter stages, with clock enable and asynchronous active-low reset. The combinational path is the primary function; the register stage is an optional tap.

## Interface
- `WIDTH`, default 1: bit width of each data input and of both outputs. Legal range is 1 to 64.
- `clk` input, 1 bit: single clock. All registered state updates on its rising edge.
- `reset_n` input, 1 bit: reset, asynchronous and active-low.
- `en` input, 1 bit: clock enable for the output register.
- `d0` input, `WIDTH` bits: data, selected when `s=2'b00`.
- `d1` input, `WIDTH` bits: data, selected when `s=2'b01`.
- `d2` input, `WIDTH` bits: data, selected when `s=2'b10`.
- `d3` input, `WIDTH` bits: data, selected when `s=2'b11`.
- `s` input, 2 bits: select.
- `y` output, `WIDTH` bits: combinational selected data.
- `y_r` output, `WIDTH` bits: registered selected data.
- `s_r` output, 2 bits: the select value captured together with `y_r`.

## Operation
- Combinational selection:
  - `y = d0` when `s=00`, `d1` when `s=01`, `d2` when `s=10`, `d3` when `s=11`.
  - Pure function of `d0..d3` and `s`. Independent of `clk`, `reset_n` and `en`.
  - `y` is valid even while `reset_n=0` and when no clock is running.
- Unknown select (simulation only): if either bit of `s` is X or Z, `y` is all-X. Synthesis treats this case as don't-care.
- Bitwise selection: bit `i` of `y` depends only on bit `i` of each data input.
- Register stage:
  - On each rising `clk` with `reset_n=1` and `en=1`: `y_r` captures the `y` value present at that edge, and `s_r` captures `s`.
  - With `en=0`: `y_r` and `s_r` hold their values.
- Reset:
  - `reset_n=0` forces `y_r=0` and `s_r=2'b00` immediately, without waiting for a clock edge.
  - Both registers stay cleared for as long as `reset_n` is low.
- No internal state other than `y_r` and `s_r`. No handshake, no FSM.

## Timing
- `y` latency is zero cycles, combinational. It settles within the same delta/time step as any change on `d*` or `s`.
- `y_r` and `s_r` latency is one `clk` rising edge after the inputs, given `en=1`.
- Reset values: `y_r=0` and `s_r=00`. `y` has no reset value; it always follows its inputs.
- Reset assertion takes effect asynchronously.
- Reset deassertion is sampled at clock edges. The first capture occurs on the first rising edge where `reset_n=1` and `en=1`.
- Simultaneous events:
  - Reset asserted at the same time as a clock edge: reset wins, registers read 0.
  - `en` is sampled at the edge. A change in `en` coinciding with the edge uses its pre-edge value.
  - `s` and `d*` changing at the same instant: `y` reflects the new pair once settled, with no ordering dependence.

## Test plan
- Select sweep with `WIDTH=1`, 10 ns steps. Each step must give `y=1`:
  - `s=00`, `d0=1`, others 0.
  - `s=01`, `d1=1`, others 0.
  - `s=10`, `d2=1`, others 0.
  - `s=11`, `d3=1`, others 0.
- Exclusion: `s=00`, `d0=0`, `d1=d2=d3=1` → `y=0`. Repeat for each select value so that only the selected input propagates.
- Combinational independence: hold `reset_n=0` and no clock, apply `s=10`, `d2=1` → `y=1` immediately, while `y_r=0` and `s_r=00`.
- Register capture with `WIDTH=8` and `en=1`: `d1=8'hA5`, `s=01` → `y=A5` at once; after the next rising edge, `y_r=A5` and `s_r=01`. Set `en=0` and change to `s=11`, `d3=8'h3C` → `y=3C`, `y_r` stays `A5`.
- Asynchronous reset mid-operation: with `y_r=A5`, pull `reset_n` low between clock edges → `y_r=00` and `s_r=00` before the next edge. Release reset with `en=1` → the next edge captures the current `y`.
- Random check: 1000 random `s` and `d*` vectors with `WIDTH=8` → `y` equals the reference selection every time.
